// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the arbiter and the
// single-ported system memory. The arbiter uses the slave modport.
interface mem_arbiter_if #(
  parameter int XLEN = 32
) ();
  logic            i_req_v;
  logic [XLEN-1:0] i_adr;
  logic            i_flush;
  logic            i_resp_v;
  logic [XLEN-1:0] i_rdata;

  logic            d_r_v;
  logic            d_w_v;
  logic [XLEN-1:0] d_adr;
  logic [XLEN-1:0] d_wdata;
  logic [3:0]      d_strobe;
  logic            d_resp_v;
  logic [XLEN-1:0] d_rdata;

  logic            m_req_v;
  logic            m_we;
  logic [XLEN-1:0] m_adr;
  logic [XLEN-1:0] m_wdata;
  logic [3:0]      m_strobe;
  logic            m_ready;
  logic            m_resp_v;
  logic [XLEN-1:0] m_rdata;

  modport slave (
    input  i_req_v, i_adr, i_flush,
    output i_resp_v, i_rdata,
    input  d_r_v, d_w_v, d_adr, d_wdata, d_strobe,
    output d_resp_v, d_rdata,
    output m_req_v, m_we, m_adr, m_wdata, m_strobe,
    input  m_ready, m_resp_v, m_rdata
  );

  modport master (
    output i_req_v, i_adr, i_flush,
    input  i_resp_v, i_rdata,
    output d_r_v, d_w_v, d_adr, d_wdata, d_strobe,
    input  d_resp_v, d_rdata,
    input  m_req_v, m_we, m_adr, m_wdata, m_strobe,
    output m_ready, m_resp_v, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data
// access: one transaction in flight, data first, fetch starvation bounded.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
  localparam logic       OWNER_I    = 1'b0;
  localparam logic       OWNER_D    = 1'b1;

  state_t          state_reg, state_next;
  logic            owner_reg, owner_next;
  logic            drop_reg, drop_next;
  logic [3:0]      streak_reg, streak_next;
  logic            m_req_v_reg, m_req_v_next;
  logic            m_we_reg, m_we_next;
  logic [XLEN-1:0] m_adr_reg, m_adr_next;
  logic [XLEN-1:0] m_wdata_reg, m_wdata_next;
  logic [3:0]      m_strobe_reg, m_strobe_next;

  logic d_pend;
  logic grant_d;
  logic grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= OWNER_I;
      drop_reg     <= 1'b0;
      streak_reg   <= 4'd0;
      m_req_v_reg  <= 1'b0;
      m_we_reg     <= 1'b0;
      m_adr_reg    <= '0;
      m_wdata_reg  <= '0;
      m_strobe_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      drop_reg     <= drop_next;
      streak_reg   <= streak_next;
      m_req_v_reg  <= m_req_v_next;
      m_we_reg     <= m_we_next;
      m_adr_reg    <= m_adr_next;
      m_wdata_reg  <= m_wdata_next;
      m_strobe_reg <= m_strobe_next;
    end
  end

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  assign d_pend  = bus.d_r_v | bus.d_w_v;
  assign grant_d = d_pend && !(bus.i_req_v && (streak_reg == STREAK_MAX));
  assign grant_i = !grant_d && bus.i_req_v && !bus.i_flush;

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    drop_next     = drop_reg;
    streak_next   = streak_reg;
    m_req_v_next  = m_req_v_reg;
    m_we_next     = m_we_reg;
    m_adr_next    = m_adr_reg;
    m_wdata_next  = m_wdata_reg;
    m_strobe_next = m_strobe_reg;

    unique case (state_reg)
      IDLE: begin
        drop_next = 1'b0;
        if (grant_d) begin
          state_next    = REQ;
          owner_next    = OWNER_D;
          m_req_v_next  = 1'b1;
          m_adr_next    = bus.d_adr;
          m_wdata_next  = bus.d_wdata;
          // Read and write asserted together is treated as a write.
          m_we_next     = bus.d_w_v;
          m_strobe_next = bus.d_w_v ? bus.d_strobe : 4'b1111;
          if (bus.i_req_v)
            streak_next = (streak_reg == STREAK_MAX) ? STREAK_MAX : streak_reg + 4'd1;
          else
            streak_next = 4'd0;
        end else if (grant_i) begin
          state_next    = REQ;
          owner_next    = OWNER_I;
          m_req_v_next  = 1'b1;
          m_adr_next    = bus.i_adr;
          m_wdata_next  = '0;
          m_we_next     = 1'b0;
          m_strobe_next = 4'b1111;
          streak_next   = 4'd0;
        end
      end
      REQ: begin
        if (bus.i_flush && owner_reg == OWNER_I)
          drop_next = 1'b1;
        if (bus.m_ready) begin
          state_next   = WAIT;
          m_req_v_next = 1'b0;
        end
      end
      WAIT: begin
        if (bus.i_flush && owner_reg == OWNER_I)
          drop_next = 1'b1;
        if (bus.m_resp_v)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.m_req_v  = m_req_v_reg;
  assign bus.m_we     = m_we_reg;
  assign bus.m_adr    = m_adr_reg;
  assign bus.m_wdata  = m_wdata_reg;
  assign bus.m_strobe = m_strobe_reg;

  // A flushed fetch still completes on the memory side; only its response is hidden.
  assign bus.i_resp_v = bus.m_resp_v && (state_reg == WAIT) && (owner_reg == OWNER_I)
                        && !drop_reg && !bus.i_flush;
  assign bus.d_resp_v = bus.m_resp_v && (state_reg == WAIT) && (owner_reg == OWNER_D);
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req_v;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        i_resp;
    logic        d_resp;
    logic [31:0] rdata;
  } txn_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts just after an edge with a request driven and the arbiter idle;
  // memory accepts in the first REQ cycle and responds the cycle after.
  task automatic run_txn(input logic [31:0] rdata, output txn_t t);
    step();
    bus.m_ready = 1'b1;
    @(negedge clk);
    t.req_v  = bus.m_req_v;
    t.we     = bus.m_we;
    t.adr    = bus.m_adr;
    t.wdata  = bus.m_wdata;
    t.strobe = bus.m_strobe;
    step();
    bus.m_ready  = 1'b0;
    bus.m_resp_v = 1'b1;
    bus.m_rdata  = rdata;
    @(negedge clk);
    t.i_resp = bus.i_resp_v;
    t.d_resp = bus.d_resp_v;
    t.rdata  = bus.d_resp_v ? bus.d_rdata : bus.i_rdata;
    step();
    bus.m_resp_v = 1'b0;
    $display("txn adr=%h we=%0d strobe=%b wdata=%h i_resp=%0d d_resp=%0d rdata=%h",
             t.adr, t.we, t.strobe, t.wdata, t.i_resp, t.d_resp, t.rdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0) begin failures++; $display("FAIL reset_m_req_v got=%b exp=0", bus.m_req_v); end
    checks++; if (bus.m_we !== 1'b0) begin failures++; $display("FAIL reset_m_we got=%b exp=0", bus.m_we); end
    checks++; if (bus.m_adr !== 32'h0) begin failures++; $display("FAIL reset_m_adr got=%h exp=0", bus.m_adr); end
    checks++; if (bus.m_wdata !== 32'h0) begin failures++; $display("FAIL reset_m_wdata got=%h exp=0", bus.m_wdata); end
    checks++; if (bus.m_strobe !== 4'h0) begin failures++; $display("FAIL reset_m_strobe got=%b exp=0000", bus.m_strobe); end
    checks++; if (bus.i_resp_v !== 1'b0 || bus.d_resp_v !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b%b exp=00", bus.i_resp_v, bus.d_resp_v); end
    rst = 1'b0;
    step();
    $display("txn reset done");
  endtask

  task automatic test_fetch_only();
    bus.i_req_v = 1'b1;
    bus.i_adr   = 32'h100;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0) begin failures++; $display("FAIL fetch_c0_req got=%b exp=0", bus.m_req_v); end
    step();
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b1) begin failures++; $display("FAIL fetch_c1_req got=%b exp=1", bus.m_req_v); end
    checks++; if (bus.m_adr !== 32'h100) begin failures++; $display("FAIL fetch_c1_adr got=%h exp=00000100", bus.m_adr); end
    checks++; if (bus.m_we !== 1'b0) begin failures++; $display("FAIL fetch_c1_we got=%b exp=0", bus.m_we); end
    checks++; if (bus.m_strobe !== 4'b1111) begin failures++; $display("FAIL fetch_c1_strobe got=%b exp=1111", bus.m_strobe); end
    step();
    bus.m_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0) begin failures++; $display("FAIL fetch_c2_req got=%b exp=0", bus.m_req_v); end
    checks++; if (bus.i_resp_v !== 1'b0) begin failures++; $display("FAIL fetch_c2_resp got=%b exp=0", bus.i_resp_v); end
    step();
    bus.m_resp_v = 1'b1;
    bus.m_rdata  = 32'h00500093;
    @(negedge clk);
    checks++; if (bus.i_resp_v !== 1'b1) begin failures++; $display("FAIL fetch_c3_resp got=%b exp=1", bus.i_resp_v); end
    checks++; if (bus.i_rdata !== 32'h00500093) begin failures++; $display("FAIL fetch_c3_rdata got=%h exp=00500093", bus.i_rdata); end
    checks++; if (bus.d_resp_v !== 1'b0) begin failures++; $display("FAIL fetch_c3_dresp got=%b exp=0", bus.d_resp_v); end
    step();
    bus.m_resp_v = 1'b0;
    bus.i_req_v  = 1'b0;
    @(negedge clk);
    checks++; if (bus.i_resp_v !== 1'b0) begin failures++; $display("FAIL fetch_c4_resp got=%b exp=0", bus.i_resp_v); end
    step();
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0) begin failures++; $display("FAIL fetch_c5_req got=%b exp=0", bus.m_req_v); end
    step();
    $display("txn fetch_only done");
  endtask

  task automatic test_simultaneous();
    txn_t t;
    bus.i_req_v  = 1'b1;
    bus.i_adr    = 32'h200;
    bus.d_w_v    = 1'b1;
    bus.d_adr    = 32'h80;
    bus.d_wdata  = 32'hDEADBEEF;
    bus.d_strobe = 4'b0011;
    run_txn(32'h0, t);
    bus.d_w_v = 1'b0;
    checks++; if (t.adr !== 32'h80) begin failures++; $display("FAIL sim_d_adr got=%h exp=00000080", t.adr); end
    checks++; if (t.we !== 1'b1) begin failures++; $display("FAIL sim_d_we got=%b exp=1", t.we); end
    checks++; if (t.wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sim_d_wdata got=%h exp=deadbeef", t.wdata); end
    checks++; if (t.strobe !== 4'b0011) begin failures++; $display("FAIL sim_d_strobe got=%b exp=0011", t.strobe); end
    checks++; if (t.d_resp !== 1'b1 || t.i_resp !== 1'b0) begin failures++; $display("FAIL sim_d_resp got=i%b d%b exp=i0 d1", t.i_resp, t.d_resp); end
    run_txn(32'hCAFE0001, t);
    bus.i_req_v = 1'b0;
    checks++; if (t.adr !== 32'h200) begin failures++; $display("FAIL sim_i_adr got=%h exp=00000200", t.adr); end
    checks++; if (t.we !== 1'b0 || t.strobe !== 4'b1111) begin failures++; $display("FAIL sim_i_rd got=we%b st%b exp=we0 st1111", t.we, t.strobe); end
    checks++; if (t.i_resp !== 1'b1 || t.d_resp !== 1'b0) begin failures++; $display("FAIL sim_i_resp got=i%b d%b exp=i1 d0", t.i_resp, t.d_resp); end
    checks++; if (t.rdata !== 32'hCAFE0001) begin failures++; $display("FAIL sim_i_rdata got=%h exp=cafe0001", t.rdata); end
    step();
  endtask

  task automatic test_starvation();
    txn_t t;
    logic [31:0] exp_adr;
    bus.i_req_v = 1'b1;
    bus.i_adr   = 32'h300;
    bus.d_r_v   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.d_adr = 32'h40 + 32'(k * 4);
      run_txn(32'h1000 + 32'(k), t);
      exp_adr = (k < 4) ? (32'h40 + 32'(k * 4)) : 32'h300;
      checks++; if (t.adr !== exp_adr) begin failures++; $display("FAIL starve_adr_%0d got=%h exp=%h", k, t.adr, exp_adr); end
      checks++; if (t.d_resp !== (k < 4) || t.i_resp !== (k == 4)) begin failures++; $display("FAIL starve_resp_%0d got=i%b d%b exp=i%0d d%0d", k, t.i_resp, t.d_resp, k == 4, k < 4); end
      if (k == 3) begin
        checks++; if (dut.streak_reg !== 4'd4) begin failures++; $display("FAIL starve_streak4 got=%0d exp=4", dut.streak_reg); end
      end
    end
    checks++; if (dut.streak_reg !== 4'd0) begin failures++; $display("FAIL starve_streak0 got=%0d exp=0", dut.streak_reg); end
    bus.i_req_v = 1'b0;
    bus.d_r_v   = 1'b0;
    step();
  endtask

  task automatic test_flush();
    txn_t t;
    bus.i_req_v = 1'b1;
    bus.i_adr   = 32'h400;
    step();
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    bus.i_flush = 1'b1;
    bus.d_r_v   = 1'b1;
    bus.d_adr   = 32'h500;
    @(negedge clk);
    checks++; if (bus.i_resp_v !== 1'b0) begin failures++; $display("FAIL flush_wait_resp got=%b exp=0", bus.i_resp_v); end
    step();
    bus.i_flush  = 1'b0;
    bus.m_resp_v = 1'b1;
    bus.m_rdata  = 32'h1234;
    @(negedge clk);
    checks++; if (bus.i_resp_v !== 1'b0) begin failures++; $display("FAIL flush_dropped_resp got=%b exp=0", bus.i_resp_v); end
    checks++; if (bus.d_resp_v !== 1'b0) begin failures++; $display("FAIL flush_dresp got=%b exp=0", bus.d_resp_v); end
    step();
    bus.m_resp_v = 1'b0;
    bus.i_req_v  = 1'b0;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0) begin failures++; $display("FAIL flush_idle_req got=%b exp=0", bus.m_req_v); end
    step();
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b1 || bus.m_adr !== 32'h500) begin failures++; $display("FAIL flush_dgrant got=req%b adr%h exp=req1 adr00000500", bus.m_req_v, bus.m_adr); end
    step();
    bus.m_ready  = 1'b0;
    bus.m_resp_v = 1'b1;
    bus.m_rdata  = 32'hABCD;
    @(negedge clk);
    checks++; if (bus.d_resp_v !== 1'b1 || bus.d_rdata !== 32'hABCD) begin failures++; $display("FAIL flush_dresp2 got=%b %h exp=1 0000abcd", bus.d_resp_v, bus.d_rdata); end
    step();
    bus.m_resp_v = 1'b0;
    bus.d_r_v    = 1'b0;
    $display("txn flush_in_wait done");

    // Flush while idle blocks the fetch grant for that cycle only.
    bus.i_req_v = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_adr   = 32'h900;
    step();
    bus.i_flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0) begin failures++; $display("FAIL flush_idle_block got=%b exp=0", bus.m_req_v); end
    run_txn(32'h77, t);
    checks++; if (t.adr !== 32'h900 || t.i_resp !== 1'b1) begin failures++; $display("FAIL flush_after_block got=adr%h i%b exp=adr00000900 i1", t.adr, t.i_resp); end

    // Flush coinciding with the response suppresses it.
    bus.i_adr = 32'hA00;
    step();
    bus.m_ready = 1'b1;
    step();
    bus.m_ready  = 1'b0;
    bus.m_resp_v = 1'b1;
    bus.m_rdata  = 32'h88;
    bus.i_flush  = 1'b1;
    @(negedge clk);
    checks++; if (bus.i_resp_v !== 1'b0) begin failures++; $display("FAIL flush_same_cycle got=%b exp=0", bus.i_resp_v); end
    step();
    bus.m_resp_v = 1'b0;
    bus.i_flush  = 1'b0;
    bus.i_req_v  = 1'b0;
    step();
    $display("txn flush_same_cycle done");
  endtask

  task automatic test_stall();
    bus.d_w_v    = 1'b1;
    bus.d_adr    = 32'h600;
    bus.d_wdata  = 32'h11223344;
    bus.d_strobe = 4'b1100;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (bus.m_req_v !== 1'b1 || bus.m_adr !== 32'h600 || bus.m_wdata !== 32'h11223344)
        begin failures++; $display("FAIL stall_hold_%0d got=req%b adr%h wd%h exp=req1 adr00000600 wd11223344", k, bus.m_req_v, bus.m_adr, bus.m_wdata); end
      step();
    end
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0) begin failures++; $display("FAIL stall_after_accept got=%b exp=0", bus.m_req_v); end
    step();
    bus.m_resp_v = 1'b1;
    @(negedge clk);
    checks++; if (bus.d_resp_v !== 1'b1) begin failures++; $display("FAIL stall_dresp got=%b exp=1", bus.d_resp_v); end
    step();
    bus.m_resp_v = 1'b0;
    bus.d_w_v    = 1'b0;
    step();
    $display("txn stall done");
  endtask

  task automatic test_reset_mid();
    txn_t t;
    bus.i_req_v = 1'b1;
    bus.i_adr   = 32'h700;
    step();
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    rst         = 1'b1;
    step();
    rst         = 1'b0;
    bus.i_req_v = 1'b0;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0 || bus.m_we !== 1'b0 || bus.m_adr !== 32'h0 || bus.m_strobe !== 4'h0)
      begin failures++; $display("FAIL rstmid_outputs got=req%b we%b adr%h st%b exp=all zero", bus.m_req_v, bus.m_we, bus.m_adr, bus.m_strobe); end
    step();
    bus.m_resp_v = 1'b1;
    bus.m_rdata  = 32'hBAD;
    @(negedge clk);
    checks++; if (bus.i_resp_v !== 1'b0 || bus.d_resp_v !== 1'b0) begin failures++; $display("FAIL rstmid_stray got=i%b d%b exp=i0 d0", bus.i_resp_v, bus.d_resp_v); end
    step();
    bus.m_resp_v = 1'b0;
    @(negedge clk);
    checks++; if (bus.m_req_v !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", bus.m_req_v); end
    step();
    bus.d_r_v = 1'b1;
    bus.d_adr = 32'h44;
    run_txn(32'h55, t);
    bus.d_r_v = 1'b0;
    checks++; if (t.adr !== 32'h44 || t.d_resp !== 1'b1 || t.rdata !== 32'h55)
      begin failures++; $display("FAIL rstmid_resume got=adr%h d%b rd%h exp=adr00000044 d1 rd00000055", t.adr, t.d_resp, t.rdata); end
    step();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.i_req_v  = 1'b0;
    bus.i_adr    = '0;
    bus.i_flush  = 1'b0;
    bus.d_r_v    = 1'b0;
    bus.d_w_v    = 1'b0;
    bus.d_adr    = '0;
    bus.d_wdata  = '0;
    bus.d_strobe = '0;
    bus.m_ready  = 1'b0;
    bus.m_resp_v = 1'b0;
    bus.m_rdata  = '0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch requester (read-only) and the data-memory requester (read/write).
- Sits between the core's imem/dmem interfaces and the system memory port.
- One transaction outstanding at a time; data has priority, with a starvation bound for fetch.
- Supports a fetch flush that discards an in-flight instruction response.

Parameters:
XLEN, 32, address/data width
STARVE_MAX, 4, max consecutive data grants while a fetch is pending (range 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
i_req_v  in  1  fetch request valid; held until i_resp_v cycle inclusive
i_adr  in  XLEN  fetch address, stable while i_req_v
i_flush  in  1  discard current/in-flight fetch
i_resp_v  out  1  fetch response pulse
i_rdata  out  XLEN  fetch data, valid with i_resp_v
d_r_v  in  1  data read request; held until d_resp_v
d_w_v  in  1  data write request; held until d_resp_v
d_adr  in  XLEN  data address
d_wdata  in  XLEN  write data
d_strobe  in  4  byte enables for writes
d_resp_v  out  1  data response/ack pulse
d_rdata  out  XLEN  read data, valid with d_resp_v
m_req_v  out  1  memory request valid
m_we  out  1  1 = write
m_adr  out  XLEN  memory address
m_wdata  out  XLEN  memory write data
m_strobe  out  4  memory byte enables; 4'b1111 for reads
m_ready  in  1  memory accepts request when m_req_v && m_ready
m_resp_v  in  1  memory response/write ack, one cycle
m_rdata  in  XLEN  memory read data

Behaviour:
- FSM states are IDLE, REQ and WAIT. Registers: owner (I/D), drop flag, streak counter (4 bits), and latched m_* fields.
- Reset (rst=1 at an edge):
  - State goes to IDLE; m_req_v, m_we, drop, streak and owner go to 0.
  - m_adr, m_wdata and m_strobe go to 0.
  - This applies mid-transaction too. A late m_resp_v arriving after reset is ignored because IDLE ignores m_resp_v.
- IDLE arbitration, evaluated each cycle:
  - Let d_pend = d_r_v|d_w_v.
  - Grant D if d_pend and not (i_req_v && streak==STARVE_MAX).
  - Else grant I if i_req_v && !i_flush.
  - On grant: latch adr/wdata/strobe/we into m_* and go to REQ. m_req_v=1 from the next cycle.
  - For a read, m_we=0 and m_strobe=4'b1111.
  - If d_r_v and d_w_v are both high, it is treated as a write.
- Streak counter:
  - A D grant while i_req_v=1 increments it (saturating at STARVE_MAX).
  - An I grant, or a D grant with i_req_v=0, clears it.
- REQ: m_req_v=1 with fields stable. On m_ready=1, go to WAIT with m_req_v=0 from the next cycle.
- WAIT: on m_resp_v, go to IDLE next cycle.
- Response pass-through is combinational:
  - i_resp_v = m_resp_v && state==WAIT && owner==I && !drop && !i_flush.
  - d_resp_v = m_resp_v && state==WAIT && owner==D.
  - i_rdata = d_rdata = m_rdata.
- Latency: request seen at cycle 0 gives m_req_v at cycle 1. With m_ready at cycle 1 and m_resp_v at cycle 2, the response is at cycle 2. A new arbitration happens at cycle 3.
- A same-cycle m_ready and m_resp_v is not allowed; the memory responds at least one cycle after acceptance.
- Flush:
  - i_flush in REQ or WAIT with owner==I sets drop. The request still completes on the memory side; it is never withdrawn.
  - The matching response is suppressed, and drop is cleared on return to IDLE.
  - i_flush in IDLE blocks an I grant that cycle.
  - i_flush has no effect on D transactions.
  - i_flush in the same cycle as m_resp_v suppresses i_resp_v.
- Requesters must drop or change their request the cycle after the response. Grants are sampled only in IDLE, one cycle after the response.

Test Plan:
- Fetch only: i_req_v=1, i_adr=0x100, m_ready at cycle 1, m_resp_v with m_rdata=0x00500093 at cycle 3 -> m_req_v=1, m_adr=0x100, m_we=0 in cycles 1-1; i_resp_v=1 with i_rdata=0x00500093 at cycle 3 only.
- Simultaneous requests, i_adr=0x200 and d_w_v with d_adr=0x80, d_wdata=0xDEADBEEF, d_strobe=4'b0011 -> D served first with m_we=1, m_strobe=4'b0011; then I is served with m_adr=0x200.
- Starvation, STARVE_MAX=4, i_req_v held, data requests back-to-back -> exactly 4 D grants, then an I grant, then streak=0.
- Flush in WAIT with owner I, memory returns 0x1234 -> i_resp_v stays 0; the FSM returns to IDLE; a pending d_r_v is granted next.
- m_ready held low for 5 cycles -> m_req_v and m_adr stay stable for all 5 cycles; no second request is issued.
- rst asserted in WAIT, then a stray m_resp_v -> all outputs 0 after the edge; no i_resp_v or d_resp_v pulse; normal operation resumes.
